// File: rtl/mx_l1_block_sched.sv
// MX level-1 block scheduler: feeds 4-product groups to an external adder and
// accumulates BLOCK_GROUPS adder results into one block result.
module mx_l1_block_sched #(
  parameter int BLOCK_GROUPS = 8,
  parameter int ACC_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_clr,
  input  logic                    cfg_valid,
  input  logic [1:0]              cfg_prec_mode,
  output logic                    cfg_ready,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_mant,
  input  logic [23:0]             in_exp,
  input  logic [3:0]              in_sign,
  output logic [15:0]             add_mant,
  output logic [23:0]             add_exp,
  output logic [3:0]              add_sign,
  output logic [1:0]              add_prec_mode,
  input  logic [9:0]              add_res_mant,
  input  logic [5:0]              add_res_exp,
  input  logic                    add_res_sign,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [5:0]              out_exp,
  output logic                    out_exp_mismatch,
  output logic [1:0]              out_prec_mode,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = (BLOCK_GROUPS > 1) ? $clog2(BLOCK_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(BLOCK_GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // cfg is ready only in IDLE, in only in RUN, out is valid only in DONE.
  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pv_q, pv_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [5:0]         exp_q, exp_d;
  logic               mism_q, mism_d;
  logic               have_exp_q, have_exp_d;
  logic [15:0]        mant_q, mant_d;
  logic [23:0]        aexp_q, aexp_d;
  logic [3:0]         sign_q, sign_d;

  logic               accept;
  logic signed [10:0] res_tc;
  logic [ACC_W-1:0]   addend;

  assign cfg_ready = (state_q == IDLE);
  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign res_tc    = {add_res_sign, add_res_mant};

  // Mode 11 returns a two's complement result; the other modes return sign-magnitude.
  always_comb begin
    addend = '0;
    if (mode_q == 2'b11) begin
      addend = ACC_W'(res_tc);
    end else if (add_res_sign) begin
      addend = ACC_W'(0) - ACC_W'(add_res_mant);
    end else begin
      addend = ACC_W'(add_res_mant);
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    pv_d       = 1'b0;
    acc_d      = acc_q;
    exp_d      = exp_q;
    mism_d     = mism_q;
    have_exp_d = have_exp_q;
    mant_d     = mant_q;
    aexp_d     = aexp_q;
    sign_d     = sign_q;

    if (pv_q) begin
      acc_d = acc_q + addend;
      if (mode_q != 2'b11) begin
        if (!have_exp_q) begin
          exp_d      = add_res_exp;
          have_exp_d = 1'b1;
        end else if (add_res_exp != exp_q) begin
          mism_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          mode_d     = cfg_prec_mode;
          acc_d      = '0;
          cnt_d      = '0;
          exp_d      = '0;
          mism_d     = 1'b0;
          have_exp_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          mant_d = in_mant;
          aexp_d = in_exp;
          sign_d = in_sign;
          pv_d   = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_GRP) state_d = FLUSH;
        end
      end
      FLUSH: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every handshake; an in-flight group is simply dropped.
    if (soft_clr) begin
      state_d    = IDLE;
      pv_d       = 1'b0;
      cnt_d      = '0;
      acc_d      = '0;
      exp_d      = '0;
      mism_d     = 1'b0;
      have_exp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      cnt_q      <= '0;
      pv_q       <= 1'b0;
      acc_q      <= '0;
      exp_q      <= '0;
      mism_q     <= 1'b0;
      have_exp_q <= 1'b0;
      mant_q     <= '0;
      aexp_q     <= '0;
      sign_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      pv_q       <= pv_d;
      acc_q      <= acc_d;
      exp_q      <= exp_d;
      mism_q     <= mism_d;
      have_exp_q <= have_exp_d;
      mant_q     <= mant_d;
      aexp_q     <= aexp_d;
      sign_q     <= sign_d;
    end
  end

  assign add_mant         = mant_q;
  assign add_exp          = aexp_q;
  assign add_sign         = sign_q;
  assign add_prec_mode    = mode_q;
  assign out_acc          = acc_q;
  assign out_exp          = exp_q;
  assign out_exp_mismatch = mism_q;
  assign out_prec_mode    = mode_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mx_l1_block_sched.sv
// Randomized bench for mx_l1_block_sched with a stub level-1 adder and a
// block-level reference model computed straight from the group data.
module tb_mx_l1_block_sched;

  localparam int BG = 8;
  localparam int AW = 12;

  logic          clk, rst_n, soft_clr;
  logic          cfg_valid, cfg_ready;
  logic [1:0]    cfg_prec_mode;
  logic          in_valid, in_ready;
  logic [15:0]   in_mant;
  logic [23:0]   in_exp;
  logic [3:0]    in_sign;
  logic [15:0]   add_mant;
  logic [23:0]   add_exp;
  logic [3:0]    add_sign;
  logic [1:0]    add_prec_mode;
  logic [9:0]    add_res_mant;
  logic [5:0]    add_res_exp;
  logic          add_res_sign;
  logic          out_valid, out_ready;
  logic signed [AW-1:0] out_acc;
  logic [5:0]    out_exp;
  logic          out_exp_mismatch;
  logic [1:0]    out_prec_mode;
  logic [1:0]    dbg_state;
  logic [AW-1:0] acc_u;

  mx_l1_block_sched #(.BLOCK_GROUPS(BG), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .cfg_valid(cfg_valid), .cfg_prec_mode(cfg_prec_mode), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .add_mant(add_mant), .add_exp(add_exp), .add_sign(add_sign),
    .add_prec_mode(add_prec_mode),
    .add_res_mant(add_res_mant), .add_res_exp(add_res_exp), .add_res_sign(add_res_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_exp(out_exp), .out_exp_mismatch(out_exp_mismatch),
    .out_prec_mode(out_prec_mode), .dbg_state(dbg_state)
  );

  assign acc_u = out_acc;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int boost = 0;

  logic [15:0] gm [BG];
  logic [5:0]  ge [BG];
  logic [3:0]  gs [BG];

  // Value of one group: mode 11 sums signed lanes; other modes return the
  // lane-magnitude sum (scaled by 16 when boosted) signed by lane 0.
  function automatic int grp_val(input logic [1:0] mode, input logic [15:0] m,
                                 input logic [3:0] s, input int bst);
    int v = 0;
    int mag = 0;
    for (int k = 0; k < 4; k++) begin
      int lm = int'(m[4*k +: 4]);
      v   += s[k] ? -lm : lm;
      mag += lm;
    end
    if (mode == 2'b11) return v;
    if (bst != 0) mag = mag * 16;
    return s[0] ? -mag : mag;
  endfunction

  // External adder stub, combinational as the real one.
  int res_i;
  always_comb begin
    res_i = grp_val(add_prec_mode, add_mant, add_sign, boost);
    if (add_prec_mode == 2'b11) begin
      add_res_sign = res_i[10];
      add_res_mant = res_i[9:0];
    end else begin
      add_res_sign = add_sign[0];
      add_res_mant = (res_i < 0) ? 10'(-res_i) : 10'(res_i);
    end
    add_res_exp = add_exp[5:0];
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_cfg(input logic [1:0] mode);
    int i = 0;
    @(negedge clk);
    while (!cfg_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid     = 1'b1;
    cfg_prec_mode = mode;
    @(negedge clk);
    cfg_valid     = 1'b0;
  endtask

  task automatic run_block(input logic [1:0] mode, input bit gaps, input int hold,
                           input string nm);
    int sum = 0;
    logic [31:0] sum_b;
    logic [AW-1:0] exp_acc;
    logic [5:0] exp_e;
    bit mm = 0;
    do_cfg(mode);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    for (int g = 0; g < BG; g++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid  = 1'b1;
      in_mant   = gm[g];
      in_exp    = {4{ge[g]}};
      in_sign   = gs[g];
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    // FLUSH cycle: keep offering junk and a foreign cfg; both must be ignored.
    out_ready     = 1'b0;
    in_valid      = 1'b1;
    in_mant       = ~gm[BG-1];
    in_sign       = ~gs[BG-1];
    cfg_valid     = 1'b1;
    cfg_prec_mode = ~mode;
    chk({nm, "_flush_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_flush_in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_add_mant_hold"}, 32'(add_mant), 32'(gm[BG-1]));

    for (int g = 0; g < BG; g++) begin
      sum += grp_val(mode, gm[g], gs[g], boost);
      if (g > 0 && ge[g] != ge[0]) mm = 1;
    end
    sum_b   = sum;
    exp_acc = sum_b[AW-1:0];
    exp_e   = (mode == 2'b11) ? 6'd0 : ge[0];
    if (mode == 2'b11) mm = 0;

    @(negedge clk);
    chk({nm, "_latency_out_valid"}, 32'(out_valid), 32'd1);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({nm, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_out_acc"}, 32'(acc_u), 32'(exp_acc));
      chk({nm, "_out_exp"}, 32'(out_exp), 32'(exp_e));
      chk({nm, "_out_mism"}, 32'(out_exp_mismatch), 32'(mm));
      chk({nm, "_out_mode"}, 32'(out_prec_mode), 32'(mode));
      chk({nm, "_add_mode"}, 32'(add_prec_mode), 32'(mode));
      chk({nm, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, "_add_mant"}, 32'(add_mant), 32'(gm[BG-1]));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_back_idle"}, 32'(cfg_ready), 32'd1);
    chk({nm, "_out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic fill(input logic [15:0] m, input logic [5:0] e, input logic [3:0] s);
    for (int g = 0; g < BG; g++) begin
      gm[g] = m;
      ge[g] = e;
      gs[g] = s;
    end
  endtask

  task automatic fill_rand();
    for (int g = 0; g < BG; g++) begin
      gm[g] = 16'($urandom);
      ge[g] = ($urandom_range(0, 3) == 0) ? 6'd5 : 6'd3;
      gs[g] = 4'($urandom);
    end
  endtask

  task automatic send_partial(input int n);
    for (int g = 0; g < n; g++) begin
      in_valid = 1'b1;
      in_mant  = 16'h4444;
      in_exp   = {4{6'd1}};
      in_sign  = 4'h0;
      @(negedge clk);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0; soft_clr = 1'b0;
    cfg_valid = 1'b0; cfg_prec_mode = 2'b00;
    in_valid = 1'b0; in_mant = '0; in_exp = '0; in_sign = '0;
    out_ready = 1'b0;
    fill(16'h0, 6'd0, 4'h0);

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc", 32'(acc_u), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    chk("rst_out_mism", 32'(out_exp_mismatch), 32'd0);
    chk("rst_out_mode", 32'(out_prec_mode), 32'd0);
    chk("rst_add_mant", 32'(add_mant), 32'd0);
    chk("rst_add_exp", 32'(add_exp), 32'd0);
    chk("rst_add_sign", 32'(add_sign), 32'd0);
    rst_n = 1'b1;

    // Mode 11, every group sums to +16.
    fill(16'h4444, 6'd2, 4'h0);
    run_block(2'b11, 0, 0, "m11_pos");

    // Mode 00, adder returns +25 per group, -25 on group 5.
    fill(16'h6667, 6'd9, 4'h0);
    gs[5] = 4'b0001;
    run_block(2'b00, 0, 0, "m00_pm25");

    // Mode 01, group 3 carries a different exponent.
    fill_rand();
    for (int g = 0; g < BG; g++) ge[g] = 6'd3;
    ge[3] = 6'd5;
    run_block(2'b01, 0, 0, "m01_mism");

    // Back-to-back with out_ready held low five cycles.
    fill_rand();
    run_block(2'b10, 0, 5, "b2b_hold");

    // Accumulator wraps: 8 x 960 modulo 2^AW.
    boost = 1;
    fill(16'hFFFF, 6'd7, 4'h0);
    run_block(2'b00, 0, 1, "wrap");
    boost = 0;

    // soft_clr after four accepts while a fifth group is offered.
    do_cfg(2'b00);
    send_partial(4);
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr = 1'b0;
    in_valid = 1'b0;
    chk("sclr_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("sclr_in_ready", 32'(in_ready), 32'd0);
    chk("sclr_out_valid", 32'(out_valid), 32'd0);
    chk("sclr_out_acc", 32'(acc_u), 32'd0);
    fill(16'h4444, 6'd2, 4'hF);
    run_block(2'b11, 0, 0, "m11_neg");

    // Asynchronous reset between clock edges mid-RUN.
    do_cfg(2'b00);
    send_partial(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_acc", 32'(acc_u), 32'd0);
    chk("arst_add_mant", 32'(add_mant), 32'd0);
    chk("arst_out_mode", 32'(out_prec_mode), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_after", 32'(dbg_state), 32'd0);
    chk("arst_no_output", 32'(out_valid), 32'd0);

    // Randomized blocks.
    for (int b = 0; b < 12; b++) begin
      boost = int'($urandom_range(0, 1));
      fill_rand();
      run_block(2'($urandom_range(0, 3)), 1, int'($urandom_range(0, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
